queue_param: RTL and testbench

Parametrised circular-buffer FIFO: the second-generation byte queue of the deserialiser datapath, generalised in data width and depth. It sits between the deserialiser's byte assembler (producer) and the downstream consumer on the single `clock_10k` domain. Compared to the first generation it adds:
- explicit simultaneous enqueue/dequeue semantics;
- a registered read with a valid strobe;
- programmable almost-full and almost-empty flags;
- sticky overflow and underflow error flags;
- a synchronous flush.

---
 rtl/queue_pkg.sv | 10 +
 rtl/queue_param_if.sv | 35 +++
 rtl/queue_mem.sv | 22 ++
 rtl/queue_param.sv | 90 +++++++++
 tb/tb_queue_param.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/queue_pkg.sv
// Shared constants and helpers for the parametrised byte queue of the deserialiser datapath.
package queue_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 8;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int len_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/queue_param_if.sv
// Producer/consumer bundle for queue_param: requests in, read data, occupancy and status flags out.
interface queue_param_if
    import queue_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
);
    localparam int LW = len_w(DEPTH);

    logic              clear_in;
    logic              enq_in;
    logic [DATA_W-1:0] data_in;
    logic              deq_in;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic [LW-1:0]     len_out;
    logic              full_out;
    logic              empty_out;
    logic              almost_full_out;
    logic              almost_empty_out;
    logic              overflow_out;
    logic              underflow_out;

    modport master (
        output clear_in, enq_in, data_in, deq_in,
        input  data_out, valid_out, len_out, full_out, empty_out,
               almost_full_out, almost_empty_out, overflow_out, underflow_out
    );

    modport slave (
        input  clear_in, enq_in, data_in, deq_in,
        output data_out, valid_out, len_out, full_out, empty_out,
               almost_full_out, almost_empty_out, overflow_out, underflow_out
    );
endinterface

// File: rtl/queue_mem.sv
// Simple dual-port storage: one write port and one registered read port, no reset.
module queue_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clock_10k,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Read samples the array before this edge's write lands, so a same-address access returns old data.
    always_ff @(posedge clock_10k) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/queue_param.sv
// Circular-buffer FIFO: pointers, occupancy, acceptance rules, threshold flags and sticky error flags.
module queue_param
    import queue_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int AF_TH  = DEPTH - 2,
    parameter int AE_TH  = 2
) (
    input  logic          clock_10k,
    input  logic          reset,
    queue_param_if.slave  bus
);
    localparam int LW = len_w(DEPTH);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("queue_param: DEPTH must be a power of two, at least 2");
    end
    if (AF_TH > DEPTH) begin : g_af_chk
        $error("queue_param: AF_TH must not exceed DEPTH");
    end
    if (AE_TH >= AF_TH) begin : g_ae_chk
        $error("queue_param: AE_TH must be below AF_TH");
    end

    logic [AW-1:0]     head_reg, tail_reg;
    logic [LW-1:0]     len_reg, len_next;
    logic              valid_reg, has_data_reg, overflow_reg, underflow_reg;
    logic              enq_ok, deq_ok, mem_we, mem_re;
    logic [DATA_W-1:0] rdata;

    always_comb begin
        deq_ok   = bus.deq_in && (len_reg != '0);
        enq_ok   = bus.enq_in && ((len_reg != LW'(DEPTH)) || deq_ok);
        mem_we   = enq_ok && !bus.clear_in;
        mem_re   = deq_ok && !bus.clear_in;
        len_next = len_reg + LW'(enq_ok) - LW'(deq_ok);
    end

    queue_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
        .clock_10k (clock_10k),
        .we        (mem_we),
        .waddr     (tail_reg),
        .wdata     (bus.data_in),
        .re        (mem_re),
        .raddr     (head_reg),
        .rdata     (rdata)
    );

    always_ff @(posedge clock_10k or negedge reset) begin
        if (!reset) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            len_reg       <= '0;
            valid_reg     <= 1'b0;
            has_data_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (bus.clear_in) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            len_reg       <= '0;
            valid_reg     <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (enq_ok) tail_reg <= tail_reg + 1'b1;
            if (deq_ok) begin
                head_reg     <= head_reg + 1'b1;
                has_data_reg <= 1'b1;
            end
            len_reg       <= len_next;
            valid_reg     <= deq_ok;
            overflow_reg  <= overflow_reg  | (bus.enq_in && !enq_ok);
            underflow_reg <= underflow_reg | (bus.deq_in && !deq_ok);
        end
    end

    // The read register has no reset; until the first dequeue since reset, present zero instead.
    assign bus.data_out         = has_data_reg ? rdata : '0;
    assign bus.valid_out        = valid_reg;
    assign bus.len_out          = len_reg;
    assign bus.full_out         = (len_reg == LW'(DEPTH));
    assign bus.empty_out        = (len_reg == '0);
    assign bus.almost_full_out  = (32'(len_reg) >= AF_TH);
    assign bus.almost_empty_out = (32'(len_reg) <= AE_TH);
    assign bus.overflow_out     = overflow_reg;
    assign bus.underflow_out    = underflow_reg;
endmodule

// File: tb/tb_queue_param.sv
// Randomised and directed bench for queue_param against a queue-based reference model, two parameter sets.
module tb_queue_param;
    logic clock_10k = 1'b0;
    logic reset     = 1'b0;
    always #5 clock_10k = ~clock_10k;

    queue_param_if #(.DATA_W(8),  .DEPTH(8)) a_if ();
    queue_param_if #(.DATA_W(16), .DEPTH(4)) b_if ();

    queue_param #(.DATA_W(8), .DEPTH(8)) dut_a (
        .clock_10k (clock_10k),
        .reset     (reset),
        .bus       (a_if.slave)
    );

    queue_param #(.DATA_W(16), .DEPTH(4), .AF_TH(2), .AE_TH(1)) dut_b (
        .clock_10k (clock_10k),
        .reset     (reset),
        .bus       (b_if.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain queues and sticky bits per instance
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    bit          m_ovf  [2];
    bit          m_unf  [2];
    bit          m_vld  [2];
    logic [15:0] m_dout [2];

    function automatic int qsize(input int sel);
        return (sel == 0) ? q0.size() : q1.size();
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int i = 0; i < 2; i++) begin
            m_ovf[i] = 0; m_unf[i] = 0; m_vld[i] = 0; m_dout[i] = '0;
        end
    endtask

    task automatic idle_inputs();
        a_if.clear_in = 0; a_if.enq_in = 0; a_if.deq_in = 0; a_if.data_in = '0;
        b_if.clear_in = 0; b_if.enq_in = 0; b_if.deq_in = 0; b_if.data_in = '0;
    endtask

    task automatic compare(input int sel);
        int dep, af, ae, n;
        logic [15:0] o_dout;
        int o_len;
        bit o_vld, o_full, o_empty, o_af, o_ae, o_ovf, o_unf;
        dep = (sel == 0) ? 8 : 4;
        af  = (sel == 0) ? 6 : 2;
        ae  = (sel == 0) ? 2 : 1;
        n   = qsize(sel);
        if (sel == 0) begin
            o_dout = {8'h00, a_if.data_out}; o_vld = a_if.valid_out; o_len = a_if.len_out;
            o_full = a_if.full_out; o_empty = a_if.empty_out; o_af = a_if.almost_full_out;
            o_ae = a_if.almost_empty_out; o_ovf = a_if.overflow_out; o_unf = a_if.underflow_out;
        end else begin
            o_dout = b_if.data_out; o_vld = b_if.valid_out; o_len = b_if.len_out;
            o_full = b_if.full_out; o_empty = b_if.empty_out; o_af = b_if.almost_full_out;
            o_ae = b_if.almost_empty_out; o_ovf = b_if.overflow_out; o_unf = b_if.underflow_out;
        end
        chk($sformatf("data_out[%0d]", sel),  32'(o_dout),  32'(m_dout[sel]));
        chk($sformatf("valid_out[%0d]", sel), 32'(o_vld),   32'(m_vld[sel]));
        chk($sformatf("len_out[%0d]", sel),   32'(o_len),   32'(n));
        chk($sformatf("full[%0d]", sel),      32'(o_full),  32'(n == dep));
        chk($sformatf("empty[%0d]", sel),     32'(o_empty), 32'(n == 0));
        chk($sformatf("afull[%0d]", sel),     32'(o_af),    32'(n >= af));
        chk($sformatf("aempty[%0d]", sel),    32'(o_ae),    32'(n <= ae));
        chk($sformatf("overflow[%0d]", sel),  32'(o_ovf),   32'(m_ovf[sel]));
        chk($sformatf("underflow[%0d]", sel), 32'(o_unf),   32'(m_unf[sel]));
    endtask

    task automatic step(input int sel, input bit clr, input bit enq, input logic [15:0] d, input bit deq);
        int dep;
        bit can_enq, can_deq;
        logic [15:0] dv;
        dep = (sel == 0) ? 8 : 4;
        dv  = (sel == 0) ? {8'h00, d[7:0]} : d;
        @(negedge clock_10k);
        idle_inputs();
        if (sel == 0) begin
            a_if.clear_in = clr; a_if.enq_in = enq; a_if.data_in = d[7:0]; a_if.deq_in = deq;
        end else begin
            b_if.clear_in = clr; b_if.enq_in = enq; b_if.data_in = d; b_if.deq_in = deq;
        end
        @(posedge clock_10k);
        if (clr) begin
            if (sel == 0) q0.delete(); else q1.delete();
            m_ovf[sel] = 0; m_unf[sel] = 0; m_vld[sel] = 0;
        end else begin
            can_deq = deq && qsize(sel) > 0;
            can_enq = enq && (qsize(sel) < dep || can_deq);
            m_vld[sel] = can_deq;
            if (can_deq) m_dout[sel] = (sel == 0) ? q0.pop_front() : q1.pop_front();
            if (can_enq) begin
                if (sel == 0) q0.push_back(dv); else q1.push_back(dv);
            end
            if (enq && !can_enq) m_ovf[sel] = 1;
            if (deq && !can_deq) m_unf[sel] = 1;
        end
        #1;
        compare(sel);
        $display("txn sel=%0d clr=%0d enq=%0d deq=%0d d=%0h len=%0d", sel, clr, enq, deq, dv, qsize(sel));
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        model_reset();
        // Reset held with enqueue requested: nothing may change
        reset = 1'b0;
        a_if.enq_in = 1; a_if.data_in = 8'h99;
        repeat (3) @(posedge clock_10k);
        #1;
        compare(0);
        compare(1);
        @(negedge clock_10k);
        idle_inputs();
        reset = 1'b1;

        // Fill then overflow
        for (int i = 0; i < 8; i++) step(0, 0, 1, 16'(8'h10 + i), 0);
        step(0, 0, 1, 16'h00FF, 0);
        // Drain then underflow
        for (int i = 0; i < 8; i++) step(0, 0, 0, 16'h0, 1);
        step(0, 0, 0, 16'h0, 1);
        // Simultaneous when full, then drain across wrap
        step(0, 1, 0, 16'h0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 16'(8'hA0 + i), 0);
        step(0, 0, 1, 16'h00B0, 1);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 16'h0, 1);
        // Simultaneous when empty
        step(0, 0, 1, 16'h0055, 1);
        step(0, 0, 0, 16'h0, 1);
        // Clear with five elements and overflow set, enqueue in the same cycle
        for (int i = 0; i < 9; i++) step(0, 0, 1, 16'(8'h30 + i), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 16'h0, 1);
        step(0, 1, 1, 16'h0077, 0);
        step(0, 0, 0, 16'h0, 1);

        // Randomised traffic
        for (int i = 0; i < 400; i++)
            step(0, ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 55),
                 16'($urandom), ($urandom_range(0, 99) < 50));

        // Reset mid-operation abandons contents
        for (int i = 0; i < 3; i++) step(0, 0, 1, 16'(8'h60 + i), 0);
        step(0, 0, 0, 16'h0, 1);
        @(negedge clock_10k);
        reset = 1'b0;
        #1;
        model_reset();
        compare(0);
        compare(1);
        @(negedge clock_10k);
        reset = 1'b1;
        step(0, 0, 1, 16'h00C3, 0);
        step(0, 0, 0, 16'h0, 1);

        // Second parameter set: 16-bit data, depth 4
        for (int i = 0; i < 4; i++) step(1, 0, 1, 16'(16'hBEEF + i), 0);
        step(1, 0, 1, 16'hDEAD, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 16'h0, 1);
        step(1, 1, 0, 16'h0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 16'(16'hBEEF + i), 0);
        step(1, 0, 1, 16'h1234, 1);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 16'h0, 1);
        for (int i = 0; i < 200; i++)
            step(1, ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 55),
                 16'($urandom), ($urandom_range(0, 99) < 50));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
